// File: rtl/ud_counter_pkg.sv
// Shared definitions for the up/down counter register interface and its bus host.
package ud_counter_pkg;

    // Register map of the counter
    localparam logic [1:0] REG_START  = 2'd0;
    localparam logic [1:0] REG_UPPER  = 2'd1;
    localparam logic [1:0] REG_LOWER  = 2'd2;
    localparam logic [1:0] REG_CYCLES = 2'd3;

    // Completion status reported by the host
    typedef enum logic [2:0] {
        StatOk         = 3'd0,
        StatCfgBad     = 3'd1,
        StatRbMismatch = 3'd2,
        StatCntErr     = 3'd3,
        StatTimeout    = 3'd4
    } status_e;

    // Host sequencer states
    typedef enum logic [3:0] {
        StIdle  = 4'd0,
        StCheck = 4'd1,
        StWr    = 4'd2,
        StTa    = 4'd3,
        StRd    = 4'd4,
        StCmp   = 4'd5,
        StStart = 4'd6,
        StRun   = 4'd7,
        StDone  = 4'd8
    } state_e;

endpackage

// File: rtl/ud_counter_bus_drv.sv
// Combinational strobe, address and data-enable generation for the counter register bus.
module ud_counter_bus_drv
    import ud_counter_pkg::*;
#(
    parameter int unsigned DW = 8
) (
    input  state_e        state_i,
    input  logic [1:0]    idx_i,
    input  logic [DW-1:0] wdata_i,
    output logic          a0_o,
    output logic          a1_o,
    output logic          ncs_o,
    output logic          nwr_o,
    output logic          nrd_o,
    output logic          oe_o,
    output logic [DW-1:0] dout_o
);

    // Strobes only assert in WR/RD, so nwr and nrd can never be low together
    always_comb begin
        a0_o   = 1'b0;
        a1_o   = 1'b0;
        ncs_o  = 1'b1;
        nwr_o  = 1'b1;
        nrd_o  = 1'b1;
        oe_o   = 1'b0;
        dout_o = '0;
        case (state_i)
            StWr: begin
                {a1_o, a0_o} = idx_i;
                ncs_o        = 1'b0;
                nwr_o        = 1'b0;
                oe_o         = 1'b1;
                dout_o       = wdata_i;
            end
            StRd: begin
                {a1_o, a0_o} = idx_i;
                ncs_o        = 1'b0;
                nrd_o        = 1'b0;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ud_counter_host.sv
// Bus-side host: validates a configuration, writes and reads back the counter
// registers, starts the counter and reports how the run ended.
module ud_counter_host
    import ud_counter_pkg::*;
#(
    parameter int unsigned DW      = 8,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [DW-1:0] cfg_start,
    input  logic [DW-1:0] cfg_upper,
    input  logic [DW-1:0] cfg_lower,
    input  logic [DW-1:0] cfg_cycles,
    output logic          A0,
    output logic          A1,
    output logic          ncs,
    output logic          nwr,
    output logic          nrd,
    inout  wire  [DW-1:0] din,
    output logic          start,
    input  logic          ec,
    input  logic          err,
    output logic          done,
    output logic [2:0]    status
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    state_e               state_q, state_d;
    logic [1:0]           idx_q, idx_d;
    logic                 ph_q, ph_d;
    logic [TW-1:0]        tmo_q, tmo_d;
    status_e              status_q, status_d;
    logic [3:0][DW-1:0]   cfg_q, cfg_d;
    logic [3:0][DW-1:0]   rb_q, rb_d;

    logic                 drv_oe;
    logic [DW-1:0]        drv_dout;

    // Next-state: sequencing, field capture, readback capture and run watchdog
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        ph_d     = ph_q;
        tmo_d    = tmo_q;
        status_d = status_q;
        cfg_d    = cfg_q;
        rb_d     = rb_q;
        case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    cfg_d[REG_START]  = cfg_start;
                    cfg_d[REG_UPPER]  = cfg_upper;
                    cfg_d[REG_LOWER]  = cfg_lower;
                    cfg_d[REG_CYCLES] = cfg_cycles;
                    status_d          = StatOk;
                    state_d           = StCheck;
                end
            end
            StCheck: begin
                if ((cfg_q[REG_LOWER] < cfg_q[REG_START]) &&
                    (cfg_q[REG_START] < cfg_q[REG_UPPER]) &&
                    (cfg_q[REG_CYCLES] != '0)) begin
                    idx_d   = 2'd0;
                    state_d = StWr;
                end else begin
                    status_d = StatCfgBad;
                    state_d  = StDone;
                end
            end
            StWr: begin
                idx_d = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    state_d = StTa;
                end
            end
            StTa: begin
                idx_d   = 2'd0;
                ph_d    = 1'b0;
                state_d = StRd;
            end
            StRd: begin
                // First cycle lets the counter settle its read data, second samples it
                if (ph_q) begin
                    rb_d[idx_q] = din;
                    ph_d        = 1'b0;
                    idx_d       = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        state_d = StCmp;
                    end
                end else begin
                    ph_d = 1'b1;
                end
            end
            StCmp: begin
                if (rb_q != cfg_q) begin
                    status_d = StatRbMismatch;
                    state_d  = StDone;
                end else begin
                    state_d = StStart;
                end
            end
            StStart: begin
                tmo_d   = TW'(TIMEOUT);
                state_d = StRun;
            end
            StRun: begin
                // err outranks ec; both outrank the watchdog expiring on the same edge
                if (err) begin
                    status_d = StatCntErr;
                    state_d  = StDone;
                end else if (ec) begin
                    status_d = StatOk;
                    state_d  = StDone;
                end else if (tmo_q <= TW'(1)) begin
                    status_d = StatTimeout;
                    state_d  = StDone;
                end else begin
                    tmo_d = tmo_q - TW'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers; reset abandons any bus cycle in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            idx_q    <= 2'd0;
            ph_q     <= 1'b0;
            tmo_q    <= '0;
            status_q <= StatOk;
            cfg_q    <= '0;
            rb_q     <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            ph_q     <= ph_d;
            tmo_q    <= tmo_d;
            status_q <= status_d;
            cfg_q    <= cfg_d;
            rb_q     <= rb_d;
        end
    end

    ud_counter_bus_drv #(
        .DW(DW)
    ) u_bus_drv (
        .state_i (state_q),
        .idx_i   (idx_q),
        .wdata_i (cfg_q[idx_q]),
        .a0_o    (A0),
        .a1_o    (A1),
        .ncs_o   (ncs),
        .nwr_o   (nwr),
        .nrd_o   (nrd),
        .oe_o    (drv_oe),
        .dout_o  (drv_dout)
    );

    assign din       = drv_oe ? drv_dout : {DW{1'bz}};
    assign cmd_ready = (state_q == StIdle);
    assign start     = (state_q == StStart);
    assign done      = (state_q == StDone);
    assign status    = status_q;

endmodule

// File: tb/tb_ud_counter_host.sv
// Directed bench for ud_counter_host with a behavioural counter register model.
module tb_ud_counter_host;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cfg_start, cfg_upper, cfg_lower, cfg_cycles;
    logic       A0, A1, ncs, nwr, nrd;
    wire  [7:0] din;
    logic       start, ec, err, done;
    logic [2:0] status;

    int vecs;
    int errs;

    // Counter register model
    logic [7:0] mem [4];
    logic       tb_oe;
    logic [7:0] tb_dout;
    logic       force07;
    logic [1:0] wa [64];
    logic [7:0] wd [64];
    int         wn;
    int         start_cnt;
    int         ncs_low_cnt;
    int         conflict_cnt;

    assign din = tb_oe ? tb_dout : 8'bz;

    ud_counter_host #(
        .DW      (8),
        .TIMEOUT (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cfg_start  (cfg_start),
        .cfg_upper  (cfg_upper),
        .cfg_lower  (cfg_lower),
        .cfg_cycles (cfg_cycles),
        .A0         (A0),
        .A1         (A1),
        .ncs        (ncs),
        .nwr        (nwr),
        .nrd        (nrd),
        .din        (din),
        .start      (start),
        .ec         (ec),
        .err        (err),
        .done       (done),
        .status     (status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Read data from the model, optionally corrupting register 2
    always_comb begin
        tb_oe   = !ncs && !nrd;
        tb_dout = (force07 && ({A1, A0} == 2'd2)) ? 8'h07 : mem[{A1, A0}];
    end

    // Write capture and log
    always @(posedge clk) begin
        if (rst && !ncs && !nwr) begin
            mem[{A1, A0}] <= din;
            if (wn < 64) begin
                wa[wn] <= {A1, A0};
                wd[wn] <= din;
            end
            wn <= wn + 1;
        end
    end

    // Bus activity monitors
    always @(negedge clk) begin
        if (start) start_cnt <= start_cnt + 1;
        if (!ncs) ncs_low_cnt <= ncs_low_cnt + 1;
        if ((!nwr && !nrd) || (dut.drv_oe && !nrd)) conflict_cnt <= conflict_cnt + 1;
    end

    // Offer one command; returns at the first falling edge after the accept edge
    task automatic issue_cmd(input logic [7:0] s, input logic [7:0] u,
                             input logic [7:0] l, input logic [7:0] c);
        @(negedge clk);
        cfg_start  = s;
        cfg_upper  = u;
        cfg_lower  = l;
        cfg_cycles = c;
        cmd_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #12;
        vecs++; if (ncs !== 1'b1) begin errs++; $display("FAIL reset_ncs got %b want 1", ncs); end
        vecs++; if (nwr !== 1'b1) begin errs++; $display("FAIL reset_nwr got %b want 1", nwr); end
        vecs++; if (nrd !== 1'b1) begin errs++; $display("FAIL reset_nrd got %b want 1", nrd); end
        vecs++; if ({A1, A0} !== 2'b00) begin errs++; $display("FAIL reset_addr got %b want 00", {A1, A0}); end
        vecs++; if (dut.drv_oe !== 1'b0) begin errs++; $display("FAIL reset_din_release got oe=%b want 0", dut.drv_oe); end
        vecs++; if (start !== 1'b0) begin errs++; $display("FAIL reset_start got %b want 0", start); end
        vecs++; if (done !== 1'b0) begin errs++; $display("FAIL reset_done got %b want 0", done); end
        vecs++; if (status !== 3'd0) begin errs++; $display("FAIL reset_status got %0d want 0", status); end
        vecs++; if (cmd_ready !== 1'b1) begin errs++; $display("FAIL reset_ready got %b want 1", cmd_ready); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_good();
        int base, sbase, n;
        logic [7:0] exp [4];
        exp[0] = 8'd3; exp[1] = 8'd4; exp[2] = 8'd2; exp[3] = 8'd2;
        base  = wn;
        sbase = start_cnt;
        issue_cmd(8'd3, 8'd4, 8'd2, 8'd2);
        vecs++; if (cmd_ready !== 1'b0) begin errs++; $display("FAIL good_ready_low got %b want 0", cmd_ready); end
        n = 1;
        while (!start && n < 40) begin @(negedge clk); n++; end
        vecs++; if (n != 16) begin errs++; $display("FAIL good_start_cycle got %0d want 16", n); end
        @(negedge clk);
        @(negedge clk);
        ec = 1'b1;
        @(negedge clk);
        ec = 1'b0;
        vecs++; if (done !== 1'b1) begin errs++; $display("FAIL good_done got %b want 1", done); end
        vecs++; if (status !== 3'd0) begin errs++; $display("FAIL good_status got %0d want 0", status); end
        @(negedge clk);
        vecs++; if (done !== 1'b0) begin errs++; $display("FAIL good_done_pulse got %b want 0", done); end
        vecs++; if (cmd_ready !== 1'b1) begin errs++; $display("FAIL good_ready_back got %b want 1", cmd_ready); end
        vecs++; if (wn - base != 4) begin errs++; $display("FAIL good_write_count got %0d want 4", wn - base); end
        for (int i = 0; i < 4; i++) begin
            vecs++;
            if (wa[base + i] !== 2'(i) || wd[base + i] !== exp[i]) begin
                errs++;
                $display("FAIL good_write%0d got addr %0d data %0d want addr %0d data %0d",
                         i, wa[base + i], wd[base + i], i, exp[i]);
            end
        end
        vecs++; if (start_cnt - sbase != 1) begin errs++; $display("FAIL good_start_pulses got %0d want 1", start_cnt - sbase); end
    endtask

    task automatic test_cfg_bad();
        int cbase, sbase;
        cbase = ncs_low_cnt;
        sbase = start_cnt;
        issue_cmd(8'd5, 8'd4, 8'd2, 8'd1);
        vecs++; if (done !== 1'b0) begin errs++; $display("FAIL cfgbad_early_done got %b want 0", done); end
        @(negedge clk);
        vecs++; if (done !== 1'b1) begin errs++; $display("FAIL cfgbad_done got %b want 1", done); end
        vecs++; if (status !== 3'd1) begin errs++; $display("FAIL cfgbad_status got %0d want 1", status); end
        @(negedge clk);
        vecs++; if (cmd_ready !== 1'b1) begin errs++; $display("FAIL cfgbad_ready got %b want 1", cmd_ready); end
        vecs++; if (status !== 3'd1) begin errs++; $display("FAIL cfgbad_status_held got %0d want 1", status); end
        vecs++; if (ncs_low_cnt != cbase) begin errs++; $display("FAIL cfgbad_ncs got %0d low cycles want 0", ncs_low_cnt - cbase); end
        vecs++; if (start_cnt != sbase) begin errs++; $display("FAIL cfgbad_start got %0d pulses want 0", start_cnt - sbase); end
        // cycles == 0 with an otherwise valid window
        issue_cmd(8'd3, 8'd4, 8'd2, 8'd0);
        @(negedge clk);
        vecs++; if (done !== 1'b1 || status !== 3'd1) begin errs++; $display("FAIL cfgbad_zero_cycles got done %b status %0d want 1 1", done, status); end
    endtask

    task automatic test_rb_mismatch();
        int sbase, n;
        sbase   = start_cnt;
        force07 = 1'b1;
        issue_cmd(8'd3, 8'd4, 8'd2, 8'd2);
        n = 1;
        while (!done && n < 40) begin @(negedge clk); n++; end
        force07 = 1'b0;
        vecs++; if (n != 16) begin errs++; $display("FAIL rbmis_done_cycle got %0d want 16", n); end
        vecs++; if (status !== 3'd2) begin errs++; $display("FAIL rbmis_status got %0d want 2", status); end
        @(negedge clk);
        vecs++; if (start_cnt != sbase) begin errs++; $display("FAIL rbmis_start got %0d pulses want 0", start_cnt - sbase); end
    endtask

    task automatic test_timeout();
        int n, early;
        issue_cmd(8'd10, 8'd200, 8'd1, 8'd5);
        n = 1;
        while (!start && n < 40) begin @(negedge clk); n++; end
        vecs++; if (n != 16) begin errs++; $display("FAIL tmo_start_cycle got %0d want 16", n); end
        early = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (done) early++;
        end
        vecs++; if (early != 0) begin errs++; $display("FAIL tmo_early_done got %0d want 0", early); end
        @(negedge clk);
        vecs++; if (done !== 1'b1) begin errs++; $display("FAIL tmo_done got %b want 1", done); end
        vecs++; if (status !== 3'd4) begin errs++; $display("FAIL tmo_status got %0d want 4", status); end
        @(negedge clk);
    endtask

    task automatic test_err_ec();
        int n;
        issue_cmd(8'd50, 8'd60, 8'd40, 8'd9);
        n = 1;
        while (!start && n < 40) begin @(negedge clk); n++; end
        @(negedge clk);
        ec  = 1'b1;
        err = 1'b1;
        @(negedge clk);
        ec  = 1'b0;
        err = 1'b0;
        vecs++; if (done !== 1'b1) begin errs++; $display("FAIL errec_done got %b want 1", done); end
        vecs++; if (status !== 3'd3) begin errs++; $display("FAIL errec_status got %0d want 3", status); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int n;
        issue_cmd(8'd3, 8'd4, 8'd2, 8'd2);
        repeat (8) @(negedge clk);
        vecs++; if (nrd !== 1'b0 || {A1, A0} !== 2'd1) begin errs++; $display("FAIL rstmid_in_read got nrd %b addr %0d want 0 1", nrd, {A1, A0}); end
        rst = 1'b0;
        #1;
        vecs++; if (ncs !== 1'b1 || nrd !== 1'b1 || nwr !== 1'b1) begin errs++; $display("FAIL rstmid_strobes got %b%b%b want 111", ncs, nwr, nrd); end
        vecs++; if ({A1, A0} !== 2'b00) begin errs++; $display("FAIL rstmid_addr got %b want 00", {A1, A0}); end
        vecs++; if (dut.drv_oe !== 1'b0) begin errs++; $display("FAIL rstmid_din_release got oe=%b want 0", dut.drv_oe); end
        vecs++; if (start !== 1'b0 || done !== 1'b0 || status !== 3'd0) begin errs++; $display("FAIL rstmid_outputs got start %b done %b status %0d want 0 0 0", start, done, status); end
        vecs++; if (cmd_ready !== 1'b1) begin errs++; $display("FAIL rstmid_ready got %b want 1", cmd_ready); end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        vecs++; if (cmd_ready !== 1'b1) begin errs++; $display("FAIL rstmid_ready_after got %b want 1", cmd_ready); end
        issue_cmd(8'd20, 8'd40, 8'd10, 8'd3);
        n = 1;
        while (!start && n < 40) begin @(negedge clk); n++; end
        vecs++; if (n != 16) begin errs++; $display("FAIL rstmid_restart_cycle got %0d want 16", n); end
        ec = 1'b1;
        n = 0;
        while (!done && n < 10) begin @(negedge clk); n++; end
        ec = 1'b0;
        vecs++; if (done !== 1'b1 || status !== 3'd0) begin errs++; $display("FAIL rstmid_restart_done got done %b status %0d want 1 0", done, status); end
        vecs++; if (mem[2] !== 8'd10 || mem[3] !== 8'd3) begin errs++; $display("FAIL rstmid_restart_regs got %0d %0d want 10 3", mem[2], mem[3]); end
        @(negedge clk);
    endtask

    initial begin
        vecs         = 0;
        errs         = 0;
        cmd_valid    = 1'b0;
        cfg_start    = '0;
        cfg_upper    = '0;
        cfg_lower    = '0;
        cfg_cycles   = '0;
        ec           = 1'b0;
        err          = 1'b0;
        force07      = 1'b0;
        wn           = 0;
        start_cnt    = 0;
        ncs_low_cnt  = 0;
        conflict_cnt = 0;
        for (int i = 0; i < 4; i++) mem[i] = '0;
        test_reset();
        test_good();
        test_cfg_bad();
        test_rb_mismatch();
        test_timeout();
        test_err_ec();
        test_reset_mid();
        vecs++; if (conflict_cnt != 0) begin errs++; $display("FAIL bus_conflict got %0d cycles want 0", conflict_cnt); end
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    // Hard bound on total run time
    initial begin
        #200000;
        $display("FAIL watchdog got no finish want finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ud_counter_host.md
# ud_counter_host

Bus-side host for the self-checking up/down counter. It takes a four-field configuration command and writes the counter's four registers over the A1/A0, ncs, nwr, nrd, din register bus. It reads all four back and compares them, then pulses `start`, waits for end-of-count (`ec`) and reports a status. It is the initiator at the other end of the counter's register interface, and replaces hand-sequenced bus stimulus in system benches and in the top level.

## Interface
Parameters:
- DW, 8, register/data width
- TIMEOUT, 1024, max cycles to wait for `ec` after `start`

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous active-low reset
- cmd_valid  in  1  configuration command offered
- cmd_ready  out  1  host idle, can accept a command
- cfg_start  in  DW  count start value (reg 0)
- cfg_upper  in  DW  upper turn point (reg 1)
- cfg_lower  in  DW  lower turn point (reg 2)
- cfg_cycles  in  DW  number of up/down cycles (reg 3)
- A0  out  1  register address bit 0
- A1  out  1  register address bit 1
- ncs  out  1  chip select, active low
- nwr  out  1  write strobe, active low
- nrd  out  1  read strobe, active low
- din  inout  DW  shared data bus, host drives only during writes
- start  out  1  one-cycle counter start pulse
- ec  in  1  counter end-of-count
- err  in  1  counter error flag
- done  out  1  one-cycle pulse when a command completes
- status  out  3  result, valid while `done`=1 and held until the next accept: 0 OK, 1 CFG_BAD, 2 RB_MISMATCH, 3 CNT_ERR, 4 TIMEOUT

## Operation
- Reset values (with rst low):
  - ncs=nwr=nrd=1, A1=A0=0
  - din hi-Z, start=0, done=0, status=0
  - cmd_ready=1, all state in IDLE
- IDLE: `cmd_ready`=1. A cycle with cmd_valid=1 captures all four cfg fields and enters CHECK.
- CHECK (1 cycle) requires all of:
  - cfg_lower < cfg_start < cfg_upper
  - cfg_cycles != 0
  - On violation: no bus activity, go to DONE with status CFG_BAD.
- WR (4 cycles), addresses 0,1,2,3 in order:
  - each cycle: ncs=0, nwr=0, nrd=1, {A1,A0}=index, din=field
  - the counter samples at the closing edge
- TA (1 cycle): ncs=nwr=nrd=1 and din released to hi-Z before any read.
- RD (2 cycles per register), addresses 0..3:
  - ncs=0, nrd=0, nwr=1, address held for both cycles
  - din captured at the edge ending the second cycle
- CMP (1 cycle): if any readback differs from the captured field, go to DONE with RB_MISMATCH and do not pulse `start`.
- START (1 cycle): start=1, bus idle (ncs=1).
- RUN: bus idle; a down-counter loaded with TIMEOUT decrements each cycle.
  - ec=1 → DONE with OK.
  - err=1 → DONE with CNT_ERR.
  - err and ec in the same cycle → CNT_ERR (err wins).
  - Counter reaching 0 → DONE with TIMEOUT.
- DONE (1 cycle): done=1, status valid; return to IDLE.
- cmd_valid outside IDLE is ignored; no queueing.
- rst low at any time immediately forces all reset values; an in-flight bus cycle is abandoned and din is released.
- Never drive din while nrd=0; never assert nwr and nrd together.

## Timing
- Accept edge = E0. CHECK E1, WR E2–E5, TA E6, RD E7–E14, CMP E15, START during cycle E15–E16.
- Earliest `done` on a good command: ec seen at edge E16+k, done during the following cycle.
- CFG_BAD: done one cycle after CHECK (2 cycles after accept).
- RB_MISMATCH: done in the cycle after CMP; start never asserted.
- TIMEOUT: done exactly TIMEOUT cycles after `start` deasserts, if ec and err stay low.
- `cmd_ready` falls in the cycle after accept and rises again in the cycle after `done`.

## Structure
- Shared package `ud_counter_pkg`:
  - register index constants REG_START=0, REG_UPPER=1, REG_LOWER=2, REG_CYCLES=3
  - status codes
  - state encoding
- One FSM module. The 2-bit register index counter and the 1-bit read sub-phase counter stay inline.
- The optional sub-module `ud_counter_bus_drv` (combinational strobe/address/tristate generation from state + index) is natural when the counter TB reuses it.

## Test plan
- Good config start=3, upper=4, lower=2, cycles=2 with real counter → bus writes 3,4,2,2 at addr 0..3, readback equal, one start pulse, done with status 0 when ec rises.
- start=5, upper=4 → status 1 two cycles after accept, ncs never low, start never high.
- Bus model returns 0x07 on addr 2 read → status 2, no start pulse.
- ec tied low, TIMEOUT=16 → status 4 exactly 16 cycles after start.
- err and ec raised in same cycle during RUN → status 3.
- rst pulsed low during RD of addr 1 → all outputs at reset values immediately, din hi-Z, cmd_ready=1 after release; a new command then completes normally.
